pclk_mode_ctrl: RTL and testbench
=================================

PCLK_MODE_CTRL -- requirements
Module: pclk_mode_ctrl

Interface
REQ-001 The block SHALL provide parameter DEF_MODE, default 2, the mode programmed automatically after reset.
REQ-002 The block SHALL provide parameter HOLD_CYC, default 16, the number of cycles timing_rst is held before dcm_go.
REQ-003 The block SHALL provide parameter TIMEOUT_CYC, default 1000000, the lock-wait limit in cycles (20-bit counter).
REQ-004 The block SHALL provide parameter SETTLE_CYC, default 64, the number of consecutive pll_locked cycles required.
REQ-005 The block SHALL provide parameter MAX_RETRY, default 3, the number of reprogram retries after a timeout.
REQ-006 The block SHALL provide the following ports, one clock domain, reset asynchronous and active-low:
  clk  in  1  programming clock (50 MHz, same as DCM PROGCLK)
  rst_  in  1  asynchronous active-low reset
  mode_sel  in  2  requested video mode index
  mode_req  in  1  one-cycle request to switch to mode_sel
  dcm_progdone  in  1  DCM SPI controller ready/done
  dcm_locked  in  1  DCM_CLKGEN LOCKED
  pll_locked  in  1  serializer PLL LOCKED
  pclk_m  out  8  DCM multiplier minus one
  pclk_d  out  8  DCM divider minus one
  dcm_go  out  1  one-cycle program strobe to the SPI controller
  timing_rst  out  1  holds timing generator and encoder in reset
  mode_cur  out  2  mode being programmed or running
  busy  out  1  high in every state except RUN and ERR
  ready  out  1  high only in RUN
  err  out  1  high only in ERR

Function
REQ-007 Mode table (M-1/D-1) SHALL be: 0 -> 62/124 (25.2 MHz), 1 -> 26/49 (27 MHz), 2 -> 198/133 (74.25 MHz), 3 -> 198/66 (148.5 MHz).
REQ-008 FSM states SHALL be HOLD, PROG, WAIT_DCM, WAIT_PLL, RUN, ERR, and all outputs SHALL be registered.
REQ-009 On HOLD entry, mode_cur, pclk_m and pclk_d SHALL load the target mode, hold-counter SHALL clear, and the registers SHALL stay stable until the next HOLD entry.
REQ-010 HOLD SHALL last exactly HOLD_CYC cycles, then go to PROG.
REQ-011 PROG SHALL last one cycle with dcm_go=1 in that cycle, then go to WAIT_DCM; dcm_go SHALL be 0 in all other states.
REQ-012 WAIT_DCM SHALL go to WAIT_PLL on the first cycle in which dcm_progdone and dcm_locked are both 1.
REQ-013 WAIT_PLL SHALL go to RUN after SETTLE_CYC consecutive cycles of pll_locked=1, and the settle counter SHALL clear on any pll_locked=0.
REQ-014 The timeout counter SHALL clear on PROG and count in WAIT_DCM/WAIT_PLL, and reaching TIMEOUT_CYC SHALL be a timeout (see REQ-022).
REQ-015 timing_rst SHALL be 1 in all states except RUN, and SHALL deassert one cycle after RUN entry.
REQ-016 mode_req in RUN or ERR SHALL cause HOLD on the next cycle with target mode_sel, including when mode_sel equals mode_cur.
REQ-017 mode_req while busy SHALL latch mode_sel into a pending register (last request wins), and the pending request SHALL be serviced by going RUN -> HOLD on the cycle after RUN entry.
REQ-018 In RUN, dcm_locked=0 or pll_locked=0 SHALL cause HOLD on the next cycle with target mode_cur; such a relock SHALL clear the retry count.
REQ-019 A mode_req in the same cycle as lock loss SHALL take priority, with target mode_sel.
REQ-020 ERR SHALL be left only by mode_req.

Reset
REQ-021 During reset, state SHALL be HOLD with target DEF_MODE, all counters 0, pending empty, timing_rst=1, busy=1, ready=0, err=0, dcm_go=0, and pclk_m/pclk_d equal to the table entry for DEF_MODE; after reset release, the sequence SHALL proceed automatically.

Configuration
REQ-022 Macro PCLK_MODE_CTRL_RETRY_EN SHALL select the timeout behaviour: defined -> timeout returns to HOLD with the same mode while retry count < MAX_RETRY and goes to ERR otherwise, with the retry count cleared on RUN entry and on mode_req; undefined -> timeout goes directly to ERR and no retry counter exists.

Verification
REQ-023 Reset release with dcm_progdone/dcm_locked high after 200 cycles and pll_locked steady -> dcm_go pulses at cycle 17, pclk_m=198, pclk_d=133, ready=1 after 64 settle cycles, timing_rst=0 the following cycle.
REQ-024 In RUN, mode_req with mode_sel=3 -> timing_rst=1 next cycle, pclk_m/pclk_d=198/66, one dcm_go pulse 16 cycles later, mode_cur=3 at RUN.
REQ-025 mode_req with mode_sel=0 then mode_req with mode_sel=1 during WAIT_DCM -> current sequence completes, then exactly one further sequence runs for mode 1 and mode 0 is never programmed again.
REQ-026 pll_locked toggling every 40 cycles in WAIT_PLL -> no RUN entry; timeout at 1000000 cycles; with PCLK_MODE_CTRL_RETRY_EN, 4 dcm_go pulses total, then err=1.
REQ-027 In RUN, pll_locked dropped for 1 cycle -> ready=0 and timing_rst=1 next cycle, reprogram of mode_cur, RUN restored with unchanged pclk_m/pclk_d.
REQ-028 rst_ asserted in WAIT_PLL -> outputs take REQ-021 values immediately, then a full DEF_MODE sequence runs.

Source files
------------

// File: rtl/pclk_mode_ctrl_if.sv
// Signal bundle between pclk_mode_ctrl and its requester / DCM / PLL neighbours.
// The master drives requests and lock status; the slave (the controller) drives programming and status.
interface pclk_mode_ctrl_if;
    logic [1:0] mode_sel;
    logic       mode_req;
    logic       dcm_progdone;
    logic       dcm_locked;
    logic       pll_locked;
    logic [7:0] pclk_m;
    logic [7:0] pclk_d;
    logic       dcm_go;
    logic       timing_rst;
    logic [1:0] mode_cur;
    logic       busy;
    logic       ready;
    logic       err;

    modport master (
        output mode_sel, mode_req, dcm_progdone, dcm_locked, pll_locked,
        input  pclk_m, pclk_d, dcm_go, timing_rst, mode_cur, busy, ready, err
    );

    modport slave (
        input  mode_sel, mode_req, dcm_progdone, dcm_locked, pll_locked,
        output pclk_m, pclk_d, dcm_go, timing_rst, mode_cur, busy, ready, err
    );
endinterface

// File: rtl/pclk_mode_ctrl.sv
// DCM_CLKGEN pixel-clock reprogramming sequencer with DCM/PLL lock supervision.
// Define PCLK_MODE_CTRL_RETRY_EN to retry the same mode up to MAX_RETRY times on lock timeout.
module pclk_mode_ctrl #(
    parameter int unsigned DEF_MODE    = 2,
    parameter int unsigned HOLD_CYC    = 16,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned SETTLE_CYC  = 64,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic            clk,
    input  logic            rst_,
    pclk_mode_ctrl_if.slave bus
);
    localparam int unsigned HW  = $clog2(HOLD_CYC + 1);
    localparam int unsigned SW  = $clog2(SETTLE_CYC + 1);
    localparam logic [1:0]  DEF = 2'(DEF_MODE);

    typedef enum logic [2:0] {HOLD, PROG, WAIT_DCM, WAIT_PLL, RUN, ERR} state_t;

    // {M-1, D-1} for each video mode
    function automatic logic [15:0] mode_md(input logic [1:0] m);
        case (m)
            2'd0:    mode_md = {8'd62,  8'd124};
            2'd1:    mode_md = {8'd26,  8'd49};
            2'd2:    mode_md = {8'd198, 8'd133};
            default: mode_md = {8'd198, 8'd66};
        endcase
    endfunction

    state_t          state, nxt;
    logic [HW-1:0]   hold_cnt;
    logic [SW-1:0]   settle_cnt;
    logic [19:0]     tmo_cnt;
    logic            pend_vld;
    logic [1:0]      pend_mode;
    logic [1:0]      mode_q;
    logic [15:0]     md_q;
    logic [1:0]      tgt;
    logic            load;
    logic            tmo_hit;
    logic            retry_ok;
    logic            busy_state;
    logic            dcm_go_d, timing_rst_d, busy_d, ready_d, err_d;
    logic            dcm_go_q, timing_rst_q, busy_q, ready_q, err_q;

    assign tmo_hit    = (tmo_cnt == 20'(TIMEOUT_CYC - 1));
    assign busy_state = (state != RUN) && (state != ERR);

`ifdef PCLK_MODE_CTRL_RETRY_EN
    logic [7:0] retry_cnt;
    assign retry_ok = (retry_cnt < 8'(MAX_RETRY));

    // Outside RUN/ERR a reload without mode_req can only be a timeout retry.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            retry_cnt <= '0;
        else if (bus.mode_req || nxt == RUN || state == RUN)
            retry_cnt <= '0;
        else if (load)
            retry_cnt <= retry_cnt + 8'd1;
    end
`else
    assign retry_ok = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            state <= HOLD;
        else
            state <= nxt;
    end

    always_comb begin
        nxt  = state;
        load = 1'b0;
        tgt  = mode_q;
        unique case (state)
            HOLD: if (hold_cnt == HW'(HOLD_CYC - 1)) nxt = PROG;
            PROG: nxt = WAIT_DCM;
            WAIT_DCM: begin
                if (bus.dcm_progdone && bus.dcm_locked)
                    nxt = WAIT_PLL;
                else if (tmo_hit) begin
                    nxt  = retry_ok ? HOLD : ERR;
                    load = retry_ok;
                end
            end
            WAIT_PLL: begin
                if (bus.pll_locked && settle_cnt == SW'(SETTLE_CYC - 1))
                    nxt = RUN;
                else if (tmo_hit) begin
                    nxt  = retry_ok ? HOLD : ERR;
                    load = retry_ok;
                end
            end
            RUN: begin
                if (bus.mode_req) begin
                    nxt  = HOLD;
                    load = 1'b1;
                    tgt  = bus.mode_sel;
                end else if (pend_vld) begin
                    nxt  = HOLD;
                    load = 1'b1;
                    tgt  = pend_mode;
                end else if (!bus.dcm_locked || !bus.pll_locked) begin
                    nxt  = HOLD;
                    load = 1'b1;
                end
            end
            ERR: begin
                if (bus.mode_req) begin
                    nxt  = HOLD;
                    load = 1'b1;
                    tgt  = bus.mode_sel;
                end
            end
            default: nxt = HOLD;
        endcase
    end

    // timing_rst rises with HOLD entry but only falls once RUN has held for a cycle.
    always_comb begin
        dcm_go_d     = (nxt == PROG);
        timing_rst_d = !((state == RUN) && (nxt == RUN));
        busy_d       = (nxt != RUN) && (nxt != ERR);
        ready_d      = (nxt == RUN);
        err_d        = (nxt == ERR);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            dcm_go_q     <= 1'b0;
            timing_rst_q <= 1'b1;
            busy_q       <= 1'b1;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            dcm_go_q     <= dcm_go_d;
            timing_rst_q <= timing_rst_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            hold_cnt   <= '0;
            settle_cnt <= '0;
            tmo_cnt    <= '0;
            pend_vld   <= 1'b0;
            pend_mode  <= '0;
            mode_q     <= DEF;
            md_q       <= mode_md(DEF);
        end else begin
            hold_cnt   <= (state == HOLD && nxt == HOLD) ? hold_cnt + HW'(1) : '0;
            settle_cnt <= (state == WAIT_PLL && bus.pll_locked) ? settle_cnt + SW'(1) : '0;
            tmo_cnt    <= (state == WAIT_DCM || state == WAIT_PLL) ? tmo_cnt + 20'd1 : '0;
            if (bus.mode_req && busy_state) begin
                pend_vld  <= 1'b1;
                pend_mode <= bus.mode_sel;
            end else if (load && !busy_state) begin
                pend_vld  <= 1'b0;
            end
            if (load) begin
                mode_q <= tgt;
                md_q   <= mode_md(tgt);
            end
        end
    end

    assign bus.pclk_m     = md_q[15:8];
    assign bus.pclk_d     = md_q[7:0];
    assign bus.mode_cur   = mode_q;
    assign bus.dcm_go     = dcm_go_q;
    assign bus.timing_rst = timing_rst_q;
    assign bus.busy       = busy_q;
    assign bus.ready      = ready_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_pclk_mode_ctrl.sv
// Self-checking bench for pclk_mode_ctrl: directed vector table, multi-cycle corner
// sequences, and a randomized run against a sequence-timing reference model.
module tb_pclk_mode_ctrl;
    localparam int unsigned HOLD    = 16;
    localparam int unsigned SETTLE  = 64;
    localparam int unsigned TMO     = 400;
    localparam int unsigned SEQ_LEN = HOLD + 2 + SETTLE;
`ifdef PCLK_MODE_CTRL_RETRY_EN
    localparam int unsigned ATTEMPTS = 4;
`else
    localparam int unsigned ATTEMPTS = 1;
`endif

    logic clk = 1'b0;
    logic rst_;
    always #5 clk = ~clk;

    pclk_mode_ctrl_if bif();

    pclk_mode_ctrl #(
        .HOLD_CYC(HOLD),
        .TIMEOUT_CYC(TMO),
        .SETTLE_CYC(SETTLE)
    ) dut (
        .clk(clk),
        .rst_(rst_),
        .bus(bif)
    );

    typedef struct {
        logic [1:0] sel;
        logic [7:0] m;
        logic [7:0] d;
    } vec_t;

    vec_t        vecs[5];
    logic [7:0]  tab_m[4] = '{8'd62, 8'd26, 8'd198, 8'd198};
    logic [7:0]  tab_d[4] = '{8'd124, 8'd49, 8'd133, 8'd66};

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned go_cnt = 0;
    logic [1:0]  go_modes[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bif.dcm_go === 1'b1) begin
            go_cnt++;
            go_modes.push_back(bif.mode_cur);
        end
    endtask

    task automatic request(input logic [1:0] sel);
        bif.mode_sel = sel;
        bif.mode_req = 1'b1;
        tick();
        bif.mode_req = 1'b0;
    endtask

    task automatic wait_ready(input int unsigned lim);
        int unsigned n = 0;
        while (bif.ready !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
        chk("wait_ready", bif.ready, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_timing_rst"}, bif.timing_rst, 1);
        chk({tag, "_busy"},       bif.busy,       1);
        chk({tag, "_ready"},      bif.ready,      0);
        chk({tag, "_err"},        bif.err,        0);
        chk({tag, "_dcm_go"},     bif.dcm_go,     0);
        chk({tag, "_pclk_m"},     bif.pclk_m,     198);
        chk({tag, "_pclk_d"},     bif.pclk_d,     133);
        chk({tag, "_mode_cur"},   bif.mode_cur,   2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned go_k, rdy_k, err_k, n;
        logic        tr_a, tr_b;
        bit          m_seq, m_pv;
        int unsigned m_t, m_age;
        logic [1:0]  m_tgt, m_pm, s;
        logic        r;
        logic [22:0] exp_v, act_v;

        vecs[0] = '{sel: 2'd3, m: 8'd198, d: 8'd66};
        vecs[1] = '{sel: 2'd0, m: 8'd62,  d: 8'd124};
        vecs[2] = '{sel: 2'd1, m: 8'd26,  d: 8'd49};
        vecs[3] = '{sel: 2'd2, m: 8'd198, d: 8'd133};
        vecs[4] = '{sel: 2'd2, m: 8'd198, d: 8'd133};

        rst_             = 1'b0;
        bif.mode_sel     = 2'd0;
        bif.mode_req     = 1'b0;
        bif.dcm_progdone = 1'b0;
        bif.dcm_locked   = 1'b0;
        bif.pll_locked   = 1'b1;

        // power-on sequence, DCM ready 200 cycles after release
        repeat (3) tick();
        chk_reset_vals("por");
        rst_ = 1'b1;
        go_cnt = 0; go_k = 0; rdy_k = 0; tr_a = 1'b0; tr_b = 1'b1;
        for (int unsigned k = 1; k <= 270; k++) begin
            tick();
            if (k == 200) begin
                bif.dcm_progdone = 1'b1;
                bif.dcm_locked   = 1'b1;
            end
            if (bif.dcm_go === 1'b1 && go_k == 0) go_k = k;
            if (bif.ready === 1'b1 && rdy_k == 0) rdy_k = k;
            if (k == 265) tr_a = bif.timing_rst;
            if (k == 266) tr_b = bif.timing_rst;
        end
        chk("por_go_cycle",    go_k,  16);
        chk("por_go_count",    go_cnt, 1);
        chk("por_ready_cycle", rdy_k, 265);
        chk("por_trst_entry",  tr_a,  1);
        chk("por_trst_after",  tr_b,  0);
        chk("por_pclk_m",      bif.pclk_m, 198);
        chk("por_pclk_d",      bif.pclk_d, 133);

        // mode table and switch timing from RUN
        for (int i = 0; i < 5; i++) begin
            go_cnt = 0;
            request(vecs[i].sel);
            chk("tbl_timing_rst", bif.timing_rst, 1);
            chk("tbl_ready",      bif.ready,      0);
            chk("tbl_pclk_m",     bif.pclk_m,     vecs[i].m);
            chk("tbl_pclk_d",     bif.pclk_d,     vecs[i].d);
            chk("tbl_mode_cur",   bif.mode_cur,   vecs[i].sel);
            n = 0;
            while (bif.dcm_go !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            chk("tbl_go_delay", n, HOLD);
            wait_ready(100);
            chk("tbl_go_count",    go_cnt,       1);
            chk("tbl_run_mode",    bif.mode_cur, vecs[i].sel);
            chk("tbl_run_pclk_m",  bif.pclk_m,   vecs[i].m);
            tick();
            chk("tbl_trst_run",    bif.timing_rst, 0);
        end

        // last-wins pending request during WAIT_DCM
        bif.dcm_progdone = 1'b0;
        go_cnt = 0;
        go_modes.delete();
        request(2'd0);
        repeat (17) tick();
        request(2'd1);
        bif.dcm_progdone = 1'b1;
        repeat (400) tick();
        chk("pend_go_count", go_cnt, 2);
        if (go_modes.size() >= 2) begin
            chk("pend_first_mode",  go_modes[0], 0);
            chk("pend_second_mode", go_modes[1], 1);
        end
        chk("pend_ready",    bif.ready,    1);
        chk("pend_mode_cur", bif.mode_cur, 1);
        chk("pend_pclk_m",   bif.pclk_m,   26);

        // one-cycle PLL drop in RUN reprograms the running mode
        go_cnt = 0;
        bif.pll_locked = 1'b0;
        tick();
        bif.pll_locked = 1'b1;
        chk("relock_ready",    bif.ready,      0);
        chk("relock_trst",     bif.timing_rst, 1);
        chk("relock_mode_cur", bif.mode_cur,   1);
        wait_ready(200);
        chk("relock_go_count", go_cnt,       1);
        chk("relock_pclk_m",   bif.pclk_m,   26);
        chk("relock_pclk_d",   bif.pclk_d,   49);

        // request coinciding with lock loss wins
        bif.dcm_locked = 1'b0;
        request(2'd0);
        bif.dcm_locked = 1'b1;
        chk("prio_mode_cur", bif.mode_cur, 0);
        chk("prio_pclk_d",   bif.pclk_d,   124);
        wait_ready(200);
        chk("prio_run_mode", bif.mode_cur, 0);

        // PLL toggling every 40 cycles never settles, so the lock wait times out
        go_cnt = 0;
        err_k = 0;
        request(2'd3);
        for (int unsigned k = 1; k <= 3000 && err_k == 0; k++) begin
            bif.pll_locked = ((k / 40) % 2) == 1;
            tick();
            if (bif.err === 1'b1) err_k = k;
        end
        chk("tmo_err_cycle", err_k, (HOLD + 1 + TMO) * ATTEMPTS);
        chk("tmo_go_count",  go_cnt, ATTEMPTS);
        chk("err_busy",      bif.busy,       0);
        chk("err_ready",     bif.ready,      0);
        chk("err_trst",      bif.timing_rst, 1);
        bif.pll_locked = 1'b1;
        repeat (50) tick();
        bif.dcm_locked = 1'b0;
        tick();
        bif.dcm_locked = 1'b1;
        tick();
        chk("err_sticky", bif.err, 1);
        request(2'd2);
        chk("err_exit_err",  bif.err,      0);
        chk("err_exit_busy", bif.busy,     1);
        chk("err_exit_mode", bif.mode_cur, 2);
        wait_ready(200);

        // asynchronous reset in WAIT_PLL
        request(2'd0);
        repeat (30) tick();
        #2;
        rst_ = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        tick();
        tick();
        chk_reset_vals("held_rst");
        rst_ = 1'b1;

        // randomized requests against the sequence-timing model
        m_seq = 1'b1; m_t = 0; m_age = 0; m_tgt = 2'd2; m_pv = 1'b0; m_pm = 2'd0;
        for (int unsigned c = 0; c < 4000; c++) begin
            r = ($urandom_range(0, 49) == 0);
            s = 2'($urandom_range(0, 3));
            bif.mode_req = r;
            bif.mode_sel = s;
            tick();
            if (m_seq) begin
                if (r) begin
                    m_pv = 1'b1;
                    m_pm = s;
                end
                if (m_t == SEQ_LEN - 1) begin
                    m_seq = 1'b0;
                    m_age = 0;
                end else begin
                    m_t++;
                end
            end else if (r || m_pv) begin
                m_tgt = r ? s : m_pm;
                m_pv  = 1'b0;
                m_seq = 1'b1;
                m_t   = 0;
            end else begin
                m_age++;
            end
            exp_v = {~m_seq, m_seq, (m_seq || m_age == 0), (m_seq && m_t == HOLD), 1'b0,
                     m_tgt, tab_m[m_tgt], tab_d[m_tgt]};
            act_v = {bif.ready, bif.busy, bif.timing_rst, bif.dcm_go, bif.err,
                     bif.mode_cur, bif.pclk_m, bif.pclk_d};
            chk("model", act_v, exp_v);
        end
        bif.mode_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
